// File: rtl/pwm_gen.sv
// PWM generator driven by an external up-counter. The compare values and mode
// are double-buffered in shadow registers that reload only on a period
// boundary (or at once while period==0), so a waveform never changes mid-period.
// The entry edge also primes prev_count, so a stale value from an earlier run
// cannot fake a boundary on the first RUN cycle.
module pwm_gen #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_en,
    input  logic [WIDTH-1:0] count_val,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] compare1,
    input  logic [WIDTH-1:0] compare2,
    input  logic [1:0]       functions,
    input  logic             cfg_update,
    output logic             pwm_out,
    output logic             period_done,
    output logic             cfg_pending
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] sh_cmp1;
    logic [WIDTH-1:0] sh_cmp2;
    logic [1:0]       sh_func;
    logic [WIDTH-1:0] prev_count;

    logic             wave;
    logic             boundary;
    logic             period_zero;
    logic             pwm_nxt;
    logic             done_nxt;
    logic             pending_nxt;
    logic             load_shadow;
    logic             load_prev;

    assign boundary    = (count_val == '0) && (prev_count != '0);
    assign period_zero = (period == '0);

    // Waveform level for the current count, taken from the shadows only.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        wave = 1'b0;
        if (sh_func[1]) begin
            wave = (count_val >= sh_cmp1) && (count_val < sh_cmp2);
        end else if (sh_func[0]) begin
            wave = (count_val >= sh_cmp1);
        end else begin
            wave = (count_val < sh_cmp1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the decisions for the output, reload and pending registers.
    always_comb begin
        state_nxt   = state;
        pwm_nxt     = 1'b0;
        done_nxt    = 1'b0;
        pending_nxt = cfg_pending;
        load_shadow = 1'b0;
        load_prev   = 1'b0;
        case (state)
            IDLE: begin
                if (pwm_en) begin
                    state_nxt   = RUN;
                    load_shadow = 1'b1;
                    pending_nxt = 1'b0;
                    load_prev   = 1'b1;
                end
            end
            RUN: begin
                if (!pwm_en) begin
                    state_nxt = IDLE;
                end else begin
                    load_prev = 1'b1;
                    done_nxt  = boundary;
                    pwm_nxt   = period_zero ? 1'b0 : wave;
                    if ((boundary || period_zero) && (cfg_pending || cfg_update)) begin
                        load_shadow = 1'b1;
                        pending_nxt = 1'b0;
                    end else if (cfg_update) begin
                        pending_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs, shadow registers and the previous-count sample.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the shadows are plain registers, so they are reset here along with everything else.
        if (!rst_n) begin
            pwm_out     <= 1'b0;
            period_done <= 1'b0;
            cfg_pending <= 1'b0;
            sh_cmp1     <= '0;
            sh_cmp2     <= '0;
            sh_func     <= '0;
            prev_count  <= '0;
        end else begin
            pwm_out     <= pwm_nxt;
            period_done <= done_nxt;
            cfg_pending <= pending_nxt;
            if (load_shadow) begin
                sh_cmp1 <= compare1;
                sh_cmp2 <= compare2;
                sh_func <= functions;
            end
            if (load_prev) begin
                prev_count <= count_val;
            end
        end
    end

endmodule

// File: tb/tb_pwm_gen.sv
// Self-checking bench for pwm_gen: a behavioural model checked every cycle,
// directed scenarios with hand-computed duty counts, then randomized traffic.
module tb_pwm_gen;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             pwm_en;
    logic [WIDTH-1:0] count_val;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] compare1;
    logic [WIDTH-1:0] compare2;
    logic [1:0]       functions;
    logic             cfg_update;
    logic             pwm_out;
    logic             period_done;
    logic             cfg_pending;

    int errors = 0;
    int checks = 0;
    int presc  = 0;

    // Behavioural model state.
    bit               m_run   = 1'b0;
    logic [WIDTH-1:0] m_c1    = '0;
    logic [WIDTH-1:0] m_c2    = '0;
    logic [1:0]       m_f     = '0;
    bit               m_pend  = 1'b0;
    logic [WIDTH-1:0] m_prev  = '0;
    bit               exp_pwm = 1'b0;
    bit               exp_done = 1'b0;

    pwm_gen #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwm_en      (pwm_en),
        .count_val   (count_val),
        .period      (period),
        .compare1    (compare1),
        .compare2    (compare2),
        .functions   (functions),
        .cfg_update  (cfg_update),
        .pwm_out     (pwm_out),
        .period_done (period_done),
        .cfg_pending (cfg_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // The waveform is high when the count lies in the half-open window [lo, hi).
    function automatic bit level(input logic [1:0] f, input int c1, input int c2, input int cnt);
        int lo;
        int hi;
        if (f[1]) begin
            lo = c1;
            hi = c2;
        end else if (f[0]) begin
            lo = c1;
            hi = 1 << WIDTH;
        end else begin
            lo = 0;
            hi = c1;
        end
        return (cnt >= lo) && (cnt < hi);
    endfunction

    // Reference model, evaluated on each rising edge and on reset assertion.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_run = 0; m_c1 = '0; m_c2 = '0; m_f = '0; m_pend = 0; m_prev = '0;
                exp_pwm = 0; exp_done = 0;
            end else if (!m_run) begin
                exp_pwm = 0;
                exp_done = 0;
                if (pwm_en) begin
                    m_run = 1; m_c1 = compare1; m_c2 = compare2; m_f = functions;
                    m_pend = 0; m_prev = count_val;
                end
            end else if (!pwm_en) begin
                m_run = 0;
                exp_pwm = 0;
                exp_done = 0;
            end else begin
                bit bnd;
                bnd = (count_val == 0) && (m_prev != 0);
                exp_done = bnd;
                exp_pwm = (period != 0) && level(m_f, int'(m_c1), int'(m_c2), int'(count_val));
                if ((m_pend || cfg_update) && (bnd || period == 0)) begin
                    m_c1 = compare1; m_c2 = compare2; m_f = functions; m_pend = 0;
                end else if (cfg_update) begin
                    m_pend = 1;
                end
                m_prev = count_val;
            end
        end
    end

    // Compare process: outputs are stable on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("pwm_out", int'(pwm_out), int'(exp_pwm));
            check("period_done", int'(period_done), int'(exp_done));
            check("cfg_pending", int'(cfg_pending), int'(m_pend));
        end
    end

    // Upstream counter 0..period with optional prescale.
    initial begin
        int pc;
        pc = 0;
        count_val = '0;
        forever begin
            @(negedge clk);
            if (pc >= presc) begin
                pc = 0;
                count_val = (int'(count_val) >= int'(period)) ? '0 : count_val + 1'b1;
            end else begin
                pc++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic window(input int n, output int highs, output int dones);
        highs = 0;
        dones = 0;
        repeat (n) begin
            tick();
            highs += int'(pwm_out);
            dones += int'(period_done);
        end
    endtask

    task automatic wait_count(input int val);
        int k;
        k = 0;
        while (int'(count_val) != val && k < 40) begin
            tick();
            k++;
        end
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!period_done && k < 40) begin
            tick();
            k++;
        end
        check(name, int'(period_done), 1);
    endtask

    task automatic pulse_update();
        cfg_update = 1'b1;
        tick();
        cfg_update = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] rnd_cmp();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return WIDTH'($urandom);
            default: return WIDTH'($urandom_range(0, 13));
        endcase
    endfunction

    // Directed scenarios followed by randomized traffic.
    initial begin
        int highs;
        int dones;
        rst_n = 1'b0; pwm_en = 1'b0; period = '0; compare1 = '0; compare2 = '0;
        functions = '0; cfg_update = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_done", int'(period_done), 0);
        check("reset_pending", int'(cfg_pending), 0);

        // Update requests while idle are ignored.
        period = 16'd9;
        pulse_update();
        tick();
        check("idle_update_ignored", int'(cfg_pending), 0);

        // Left aligned, cmp1=3: three high steps per ten-step period.
        compare1 = 16'd3; functions = 2'b00; pwm_en = 1'b1;
        repeat (12) tick();
        window(10, highs, dones);
        check("left_duty3", highs, 3);
        check("left_done_per_wrap", dones, 1);

        // Shadowed update: request at count 4 stays pending until the wrap.
        wait_count(4);
        compare1 = 16'd7;
        pulse_update();
        check("shadow_pending_set", int'(cfg_pending), 1);
        wait_done("shadow_wrap");
        check("shadow_pending_clear", int'(cfg_pending), 0);
        window(10, highs, dones);
        check("shadow_duty7", highs, 7);

        // Update in the same cycle as a boundary applies at once.
        wait_count(0);
        compare1 = 16'd5;
        pulse_update();
        check("simul_no_pending", int'(cfg_pending), 0);
        check("simul_boundary", int'(period_done), 1);
        window(10, highs, dones);
        check("simul_duty5", highs, 5);

        // Unaligned window [2,6), then an inverted window gives constant 0.
        pwm_en = 1'b0;
        tick();
        functions = 2'b10; compare1 = 16'd2; compare2 = 16'd6; pwm_en = 1'b1;
        repeat (12) tick();
        window(10, highs, dones);
        check("unaligned_duty4", highs, 4);
        compare1 = 16'd6; compare2 = 16'd2;
        pulse_update();
        wait_done("unaligned_wrap");
        window(10, highs, dones);
        check("unaligned_inverted", highs, 0);

        // Right aligned extremes.
        functions = 2'b01; compare1 = 16'd0;
        pulse_update();
        wait_done("right0_wrap");
        window(10, highs, dones);
        check("right_cmp0_const1", highs, 10);
        compare1 = 16'hFFFF;
        pulse_update();
        wait_done("rightmax_wrap");
        window(10, highs, dones);
        check("right_cmpmax_const0", highs, 0);

        // period==0 applies a reload immediately and holds the output low.
        period = '0; functions = 2'b00; compare1 = 16'd9;
        pulse_update();
        check("period0_no_pending", int'(cfg_pending), 0);
        tick();
        check("period0_pwm_low", int'(pwm_out), 0);
        period = 16'd9;

        // Asynchronous reset while high and pending.
        wait_count(3);
        pulse_update();
        check("pre_reset_pwm", int'(pwm_out), 1);
        check("pre_reset_pending", int'(cfg_pending), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_pwm", int'(pwm_out), 0);
        check("async_reset_pending", int'(cfg_pending), 0);
        tick();
        pwm_en = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_reset_idle", int'(pwm_out), 0);
        end
        pwm_en = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            tick();
            cfg_update = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) begin
                compare1 = rnd_cmp();
                compare2 = rnd_cmp();
                functions = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 59) == 0)
                period = ($urandom_range(0, 5) == 0) ? '0 : WIDTH'($urandom_range(1, 12));
            if ($urandom_range(0, 99) == 0)
                presc = $urandom_range(0, 2);
            if (pwm_en) begin
                if ($urandom_range(0, 49) == 0) pwm_en = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                pwm_en = 1'b1;
            end
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
        end
        cfg_update = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the width of the count and compare values.
REQ-002 The block SHALL have port clk  input  1  the single peripheral clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port pwm_en  input  1  level enable; 0 = IDLE, 1 = RUN.
REQ-005 The block SHALL have port count_val  input  WIDTH  the upstream counter value, which may hold for many clocks under prescale.
REQ-006 The block SHALL have port period  input  WIDTH  the live period value, used only for the period==0 check.
REQ-007 The block SHALL have port compare1  input  WIDTH  the live first compare value.
REQ-008 The block SHALL have port compare2  input  WIDTH  the live second compare value.
REQ-009 The block SHALL have port functions  input  2  the live mode: bit1=0 aligned, bit1=1 unaligned; bit0 selects left (0) or right (1) when aligned.
REQ-010 The block SHALL have port cfg_update  input  1  a one-clock pulse requesting a shadow reload.
REQ-011 The block SHALL have port pwm_out  output  1  the registered PWM waveform.
REQ-012 The block SHALL have port period_done  output  1  a one-clock pulse on each detected period boundary.
REQ-013 The block SHALL have port cfg_pending  output  1  a flag that is high while a requested reload has not yet been applied.

Function
REQ-014 The block SHALL hold shadow registers sh_cmp1, sh_cmp2 and sh_func, and SHALL generate the waveform only from these shadows, never from the live inputs.
REQ-015 The block SHALL implement two states: IDLE and RUN.
REQ-016 IDLE to RUN SHALL occur on the first clock with pwm_en=1; that same edge SHALL load all shadows from the live inputs and clear cfg_pending.
REQ-017 RUN to IDLE SHALL occur on the first clock with pwm_en=0; the same edge SHALL force pwm_out to 0, while the shadows and cfg_pending retain their values.
REQ-018 The block SHALL register count_val into prev_count every clock in RUN.
REQ-019 A boundary SHALL be count_val==0 with prev_count!=0, evaluated only in RUN, excluding the entry cycle.
REQ-020 On a boundary, period_done SHALL be 1 for exactly the next clock.
REQ-021 cfg_update=1 in RUN with no boundary in the same cycle SHALL set cfg_pending on the next edge.
REQ-022 On a boundary with cfg_pending=1 or with cfg_update=1 in that cycle, the block SHALL load the shadows from the live inputs and SHALL clear cfg_pending on the same edge.
REQ-023 cfg_update in IDLE SHALL be ignored.
REQ-024 cfg_update on the RUN entry cycle SHALL be absorbed by the entry load.
REQ-025 When period==0 in RUN, pending or requested reloads SHALL apply on the next edge without waiting for a boundary, and pwm_out SHALL be 0.
REQ-026 Left-aligned mode (func=00) SHALL compute next pwm_out = (count_val < sh_cmp1); sh_cmp1=0 gives a constant 0.
REQ-027 Right-aligned mode (func=01) SHALL compute next pwm_out = (count_val >= sh_cmp1); sh_cmp1=0 gives a constant 1.
REQ-028 Unaligned mode (func=1x) SHALL compute next pwm_out = (sh_cmp1 <= count_val) and (count_val < sh_cmp2); sh_cmp1 >= sh_cmp2 gives a constant 0.
REQ-029 All compares SHALL be unsigned at WIDTH bits; a compare value greater than the counter maximum SHALL saturate naturally, with no wrap.
REQ-030 pwm_out SHALL have a latency of exactly one clock from count_val.
REQ-031 On a reload edge, the new shadow values SHALL take effect for the following computation; the current edge's pwm_out SHALL use the old shadows.

Reset
REQ-032 rst_n=0 SHALL immediately, without waiting for clk, force: state IDLE, pwm_out 0, period_done 0, cfg_pending 0, shadows 0, prev_count 0.
REQ-033 Reset mid-period SHALL discard any pending reload.
REQ-034 After rst_n releases, the block SHALL stay in IDLE until pwm_en=1 is sampled.

Verification
REQ-035 Left-aligned: period=9, func=00, cmp1=3, count 0..9 repeating -> pwm_out high for 3 of 10 count steps, delayed one clock; period_done pulses once per wrap.
REQ-036 Unaligned: func=10, cmp1=2, cmp2=6 -> pwm_out high for counts 2..5. Then cmp1=6, cmp2=2 -> pwm_out constant 0 after the next boundary.
REQ-037 Shadowed update: at count 4, drive cmp1 3->7 with cfg_update -> cfg_pending=1, duty unchanged until wrap, then duty 7 and cfg_pending=0.
REQ-038 Simultaneous: cfg_update in the same cycle as a boundary -> reload applies on that edge and cfg_pending never rises.
REQ-039 Right-aligned extremes: func=01 with cmp1=0 -> constant 1; cmp1=16'hFFFF with period=9 -> constant 0.
REQ-040 Reset mid-operation: assert rst_n=0 between clock edges while pwm_out=1 and cfg_pending=1 -> both go to 0 immediately; pwm_out stays 0 until re-enabled.
